soc_system_led_pio_blink: RTL and testbench

- Parametrised successor to the single-register Avalon-MM output PIO.
- Provides a DATA register plus atomic SET, CLR and TOGGLE strobes.
- Adds per-bit hardware blink driven by a programmable half-period prescaler, so the HPS can start a heartbeat LED and leave it running without software toggling.
- Sits on the lightweight HPS-to-FPGA bridge as an Avalon-MM slave; out_port drives the LEDs.

---
 rtl/soc_system_led_pio_blink.sv | 64 ++++++
 tb/tb_soc_system_led_pio_blink.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/soc_system_led_pio_blink.sv
// soc_system_led_pio_blink: Avalon-MM LED PIO with set/clear/toggle strobes and per-bit hardware blink
module soc_system_led_pio_blink #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_PERIOD = CNT_WIDTH'(12499999)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  blink_phase
);
  logic [DATA_WIDTH-1:0] data_q, data_d, blink_q, blink_d;
  logic [CNT_WIDTH-1:0]  period_q, period_d, cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic                  wr, per_wr, tc;
  always_comb begin
    wr       = chipselect & ~write_n;
    per_wr   = wr && address == 3'd5;
    tc       = cnt_q == period_q;
    data_d   = !wr              ? data_q :
               address == 3'd0 ? writedata :
               address == 3'd1 ? data_q | writedata :
               address == 3'd2 ? data_q & ~writedata :
               address == 3'd3 ? data_q ^ writedata : data_q;
    blink_d  = (wr && address == 3'd4) ? writedata : blink_q;
    period_d = per_wr ? writedata[CNT_WIDTH-1:0] : period_q;
    // A PERIOD write restarts the blink cleanly and outranks a coincident terminal count
    cnt_d    = (per_wr || tc) ? '0 : cnt_q + CNT_WIDTH'(1);
    phase_d  = per_wr ? 1'b1 : tc ? ~phase_q : phase_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      blink_q  <= '0;
      period_q <= DEFAULT_PERIOD;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end
  always_comb begin
    readdata = '0;
    case (address)
      3'd0, 3'd1: readdata = data_q;
      3'd4:       readdata = blink_q;
      3'd5:       readdata = DATA_WIDTH'(period_q);
      3'd6:       readdata = DATA_WIDTH'(phase_q);
      default:    ;
    endcase
  end
  assign blink_phase = phase_q;
  assign out_port    = data_q & (~blink_q | {DATA_WIDTH{phase_q}});
endmodule

// File: tb/tb_soc_system_led_pio_blink.sv
// tb_soc_system_led_pio_blink: directed checks of register map, prescaler timing and async reset
module tb_soc_system_led_pio_blink;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata, out_port;
  logic        blink_phase;
  int          vec = 0;
  int          err = 0;

  soc_system_led_pio_blink #(
    .DATA_WIDTH(32), .CNT_WIDTH(24), .RESET_VALUE(32'h5), .DEFAULT_PERIOD(24'd3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    #1;
  endtask

  task automatic test_restart();
    logic exp;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = ((k / 4) % 2) == 0;
      vec++;
      if (blink_phase !== exp) begin
        err++;
        $display("FAIL restart_phase k=%0d got %b want %b", k, blink_phase, exp);
      end
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    vec++;
    if (out_port !== 32'h5) begin err++; $display("FAIL reset_out got %h want 00000005", out_port); end
    rd(3'd5);
    vec++;
    if (readdata !== 32'h3) begin err++; $display("FAIL reset_period got %h want 00000003", readdata); end
    rd(3'd6);
    vec++;
    if (readdata !== 32'h1) begin err++; $display("FAIL reset_status got %h want 00000001", readdata); end
    rd(3'd4);
    vec++;
    if (readdata !== 32'h0) begin err++; $display("FAIL reset_blink_en got %h want 00000000", readdata); end
    @(posedge clk);
    test_restart();
  endtask

  task automatic test_regs();
    logic [2:0]  wa [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] wd [4] = '{32'hF0, 32'h0F, 32'h30, 32'h101};
    logic [31:0] ed [4] = '{32'hF0, 32'hFF, 32'hCF, 32'h1CE};
    logic [31:0] er [4] = '{32'hF0, 32'hFF, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      wr(wa[i], wd[i]);
      rd(3'd0);
      vec++;
      if (readdata !== ed[i]) begin err++; $display("FAIL data_after_op%0d got %h want %h", i, readdata, ed[i]); end
      vec++;
      if (out_port !== ed[i]) begin err++; $display("FAIL out_after_op%0d got %h want %h", i, out_port, ed[i]); end
      rd(wa[i]);
      vec++;
      if (readdata !== er[i]) begin err++; $display("FAIL readback_addr%0d got %h want %h", wa[i], readdata, er[i]); end
    end
  endtask

  task automatic test_blink();
    logic [31:0] exp;
    wr(3'd0, 32'hFF);
    wr(3'd4, 32'h01);
    wr(3'd5, 32'h1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      exp = (((k / 2) % 2) == 0) ? 32'hFF : 32'hFE;
      vec++;
      if (out_port !== exp) begin err++; $display("FAIL blink_out k=%0d got %h want %h", k, out_port, exp); end
    end
    wr(3'd0, 32'hFE);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      vec++;
      if (out_port !== 32'hFE) begin err++; $display("FAIL blink_masked k=%0d got %h want 000000fe", k, out_port); end
    end
  endtask

  task automatic test_period_write();
    wr(3'd5, 32'd9);
    repeat (10) tick();
    vec++;
    if (blink_phase !== 1'b0) begin err++; $display("FAIL p9_toggle got %b want 0", blink_phase); end
    repeat (7) tick();
    vec++;
    if (blink_phase !== 1'b0) begin err++; $display("FAIL p9_cnt7 got %b want 0", blink_phase); end
    wr(3'd5, 32'd2);
    vec++;
    if (blink_phase !== 1'b1) begin err++; $display("FAIL pwr_force got %b want 1", blink_phase); end
    tick(); tick();
    vec++;
    if (blink_phase !== 1'b1) begin err++; $display("FAIL pwr_hold got %b want 1", blink_phase); end
    tick();
    vec++;
    if (blink_phase !== 1'b0) begin err++; $display("FAIL pwr_toggle3 got %b want 0", blink_phase); end
    repeat (3) tick();
    vec++;
    if (blink_phase !== 1'b1) begin err++; $display("FAIL pwr_toggle6 got %b want 1", blink_phase); end
    tick(); tick();
    wr(3'd5, 32'd2);
    vec++;
    if (blink_phase !== 1'b1) begin err++; $display("FAIL pwr_at_tc got %b want 1", blink_phase); end
    tick(); tick();
    vec++;
    if (blink_phase !== 1'b1) begin err++; $display("FAIL pwr_at_tc_hold got %b want 1", blink_phase); end
    tick();
    vec++;
    if (blink_phase !== 1'b0) begin err++; $display("FAIL pwr_at_tc_next got %b want 0", blink_phase); end
  endtask

  task automatic test_misc();
    wr(3'd5, 32'hFFFF_FFFF);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd5);
    vec++;
    if (readdata !== 32'h00FF_FFFF) begin err++; $display("FAIL period_trunc got %h want 00ffffff", readdata); end
    rd(3'd0);
    vec++;
    if (readdata !== 32'hFE) begin err++; $display("FAIL ign_data got %h want 000000fe", readdata); end
    rd(3'd4);
    vec++;
    if (readdata !== 32'h01) begin err++; $display("FAIL ign_blink_en got %h want 00000001", readdata); end
    rd(3'd7);
    vec++;
    if (readdata !== 32'h0) begin err++; $display("FAIL addr7_read got %h want 00000000", readdata); end
    rd(3'd6);
    vec++;
    if (readdata !== 32'h1) begin err++; $display("FAIL status_read got %h want 00000001", readdata); end
  endtask

  task automatic test_async_reset();
    wr(3'd0, 32'h0F);
    wr(3'd4, 32'h0F);
    wr(3'd5, 32'd3);
    repeat (5) tick();
    vec++;
    if (out_port !== 32'h0) begin err++; $display("FAIL pre_reset_out got %h want 00000000", out_port); end
    #3 reset_n = 1'b0;
    #1;
    vec++;
    if (out_port !== 32'h5) begin err++; $display("FAIL async_out got %h want 00000005", out_port); end
    vec++;
    if (blink_phase !== 1'b1) begin err++; $display("FAIL async_phase got %b want 1", blink_phase); end
    rd(3'd4);
    vec++;
    if (readdata !== 32'h0) begin err++; $display("FAIL async_blink_en got %h want 00000000", readdata); end
    rd(3'd5);
    vec++;
    if (readdata !== 32'h3) begin err++; $display("FAIL async_period got %h want 00000003", readdata); end
    test_restart();
  endtask

  initial begin
    test_reset();
    test_regs();
    test_blink();
    test_period_write();
    test_misc();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
